seg_scan_ctrl: RTL and testbench

Parametrised multiplexed-display scan controller for the vending machine front panel. It steps a digit-select index across N_DIGITS common-anode/cathode digits, advancing on rising edges of an externally generated scan strobe. It adds per-digit enable with skip-over, PWM brightness with a built-in inter-digit blanking guard, per-digit blink gating and a frame-complete pulse. It sits between the refresh prescaler and the segment mux, which consumes S to pick the segment pattern.

---
 rtl/seg_scan_ctrl.sv | 95 +++++++++
 tb/tb_seg_scan_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed display scan controller: steps a digit select on scan-strobe edges,
// skipping disabled digits, with PWM brightness, blink gating and a frame pulse.
module seg_scan_ctrl #(
    parameter int N_DIGITS      = 4,
    parameter int SEL_W         = 2,
    parameter int BRIGHT_W      = 3,
    parameter int AN_ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                tick,
    input  logic [N_DIGITS-1:0] digit_en,
    input  logic [N_DIGITS-1:0] blink_mask,
    input  logic                blink_phase,
    input  logic [BRIGHT_W-1:0] bright,
    output logic [N_DIGITS-1:0] AN,
    output logic [SEL_W-1:0]    S,
    output logic                frame_done
);

    localparam logic [N_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
    localparam logic [BRIGHT_W-1:0] PH_LAST = {BRIGHT_W{1'b1}};

    // One extra bit so S+k can exceed N_DIGITS before the modulo fold.
    typedef logic [SEL_W:0] ext_t;

    logic                tick_q;
    logic [BRIGHT_W-1:0] ph_q, ph_d;
    logic [SEL_W-1:0]    s_q, s_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic                fd_q, fd_d;

    logic                tick_edge, slot_end, drive;
    logic [SEL_W-1:0]    nxt_sel;
    logic                nxt_found;
    ext_t                cand;

    assign tick_edge = tick & ~tick_q;
    assign slot_end  = tick_edge && (ph_q == PH_LAST);

    // Search S+N..S+1 so the nearest enabled digit after S is the one kept;
    // k = N_DIGITS lands back on S, covering the single-enabled-digit case.
    always_comb begin
        nxt_sel   = s_q;
        nxt_found = 1'b0;
        cand      = '0;
        for (int k = N_DIGITS; k >= 1; k--) begin
            cand = {1'b0, s_q} + ext_t'(k);
            if (cand >= ext_t'(N_DIGITS))
                cand = cand - ext_t'(N_DIGITS);
            if (digit_en[cand[SEL_W-1:0]]) begin
                nxt_sel   = cand[SEL_W-1:0];
                nxt_found = 1'b1;
            end
        end
    end

    always_comb begin
        ph_d = ph_q;
        s_d  = s_q;
        fd_d = 1'b0;
        if (tick_edge)
            ph_d = ph_q + BRIGHT_W'(1);
        if (slot_end && nxt_found) begin
            s_d  = nxt_sel;
            fd_d = (nxt_sel <= s_q);
        end
        // ph < bright means the last phase of a slot is always dark.
        drive = digit_en[s_q] & ~(blink_mask[s_q] & blink_phase) & (ph_q < bright);
        an_d  = AN_OFF;
        if (drive)
            an_d[s_q] = ~AN_OFF[s_q];
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            tick_q <= 1'b0;
            ph_q   <= '0;
            s_q    <= '0;
            an_q   <= AN_OFF;
            fd_q   <= 1'b0;
        end else begin
            tick_q <= tick;
            ph_q   <= ph_d;
            s_q    <= s_d;
            an_q   <= an_d;
            fd_q   <= fd_d;
        end
    end

    assign AN         = an_q;
    assign S          = s_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: table of whole-scan scenarios, directed reset/strobe
// corner cases, and a randomized run against an edge-counting reference model.
module tb_seg_scan_ctrl;

    logic       clk = 1'b0, clr = 1'b0, tick = 1'b0, bp = 1'b0;
    logic [2:0] bright = 3'd0;
    logic [3:0] en4 = 4'h0, mk4 = 4'h0, an4;
    logic [1:0] s4;
    logic       fd4;
    logic [5:0] en6 = 6'h0, mk6 = 6'h0, an6;
    logic [2:0] s6;
    logic       fd6;
    int         total = 0, bad = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl dut4 (
        .clk(clk), .clr(clr), .tick(tick), .digit_en(en4), .blink_mask(mk4),
        .blink_phase(bp), .bright(bright), .AN(an4), .S(s4), .frame_done(fd4)
    );

    seg_scan_ctrl #(.N_DIGITS(6), .SEL_W(3), .BRIGHT_W(3), .AN_ACTIVE_LOW(0)) dut6 (
        .clk(clk), .clr(clr), .tick(tick), .digit_en(en6), .blink_mask(mk6),
        .blink_phase(bp), .bright(bright), .AN(an6), .S(s6), .frame_done(fd6)
    );

    // Reference: counts strobe edges, a slot is 8 of them, and at each slot end
    // jumps to the next enabled digit found by modular search.
    typedef struct {
        bit          tq;
        int          ph;
        int          s;
        logic [15:0] an;
        bit          fd;
    } mst_t;
    mst_t m[2];

    function automatic void mreset(int i, bit alow);
        m[i].tq = 1'b0; m[i].ph = 0; m[i].s = 0; m[i].fd = 1'b0;
        m[i].an = alow ? 16'hFFFF : 16'h0000;
    endfunction

    function automatic void mstep(int i, int n, bit alow, bit tk, logic [15:0] en,
                                  logic [15:0] mk, bit bphase, int br);
        bit drv;
        drv = en[m[i].s] && !(mk[m[i].s] && bphase) && (m[i].ph < br);
        m[i].an = alow ? 16'hFFFF : 16'h0000;
        if (drv) m[i].an[m[i].s] = !alow;
        m[i].fd = 1'b0;
        if (tk && !m[i].tq) begin
            if (m[i].ph == 7) begin
                for (int k = 1; k <= n; k++) begin
                    int idx;
                    idx = (m[i].s + k) % n;
                    if (en[idx]) begin
                        m[i].fd = (idx <= m[i].s);
                        m[i].s  = idx;
                        break;
                    end
                end
            end
            m[i].ph = (m[i].ph + 1) % 8;
        end
        m[i].tq = tk;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Called at a negedge with inputs already set; returns at the next negedge.
    task automatic cyc();
        @(posedge clk);
        mstep(0, 4, 1'b1, tick, {12'b0, en4}, {12'b0, mk4}, bp, int'(bright));
        mstep(1, 6, 1'b0, tick, {10'b0, en6}, {10'b0, mk6}, bp, int'(bright));
        #1;
        check("cyc4 {S,AN,fd}", {s4, an4, fd4}, {2'(m[0].s), m[0].an[3:0], m[0].fd});
        check("cyc6 {S,AN,fd}", {s6, an6, fd6}, {3'(m[1].s), m[1].an[5:0], m[1].fd});
        @(negedge clk);
    endtask

    task automatic do_reset();
        clr = 1'b1;
        #1;
        check("rst_s4", 32'(s4), 0);
        check("rst_an4", 32'(an4), 32'hF);
        check("rst_fd4", 32'(fd4), 0);
        check("rst_s6", 32'(s6), 0);
        check("rst_an6", 32'(an6), 0);
        mreset(0, 1'b1);
        mreset(1, 1'b0);
        @(negedge clk);
        clr = 1'b0;
    endtask

    typedef struct {
        logic [3:0]      en;
        logic [2:0]      br;
        logic [3:0]      mk;
        logic            bph;
        int              edges;
        int              fd;
        int              s;
        logic [3:0][7:0] on;   // per-digit driven samples, [3] first
    } vec_t;
    vec_t tbl[7];

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{4'hF, 3'd7, 4'h0, 1'b0, 32, 1, 0, {8'd7,  8'd7, 8'd7,  8'd7}};
        tbl[1] = '{4'hA, 3'd7, 4'h0, 1'b0, 32, 1, 3, {8'd8,  8'd0, 8'd14, 8'd0}};
        tbl[2] = '{4'hF, 3'd0, 4'h0, 1'b0, 16, 0, 2, {8'd0,  8'd0, 8'd0,  8'd0}};
        tbl[3] = '{4'hF, 3'd3, 4'h0, 1'b0, 16, 0, 2, {8'd0,  8'd1, 8'd3,  8'd2}};
        tbl[4] = '{4'hF, 3'd7, 4'h4, 1'b1, 32, 1, 0, {8'd7,  8'd0, 8'd7,  8'd7}};
        tbl[5] = '{4'h8, 3'd7, 4'h0, 1'b0, 32, 3, 3, {8'd22, 8'd0, 8'd0,  8'd0}};
        tbl[6] = '{4'h0, 3'd7, 4'h0, 1'b0, 16, 0, 0, {8'd0,  8'd0, 8'd0,  8'd0}};

        @(negedge clk);
        for (int r = 0; r < 7; r++) begin
            int fdc;
            int onc[4];
            en4 = tbl[r].en; bright = tbl[r].br; mk4 = tbl[r].mk; bp = tbl[r].bph;
            en6 = 6'h3F; mk6 = 6'h0; tick = 1'b0;
            do_reset();
            fdc = 0;
            onc = '{0, 0, 0, 0};
            for (int e = 0; e < tbl[r].edges; e++) begin
                tick = 1'b1; cyc(); fdc += int'(fd4);
                tick = 1'b0; cyc(); fdc += int'(fd4);
                for (int d = 0; d < 4; d++) if (an4[d] == 1'b0) onc[d]++;
            end
            check($sformatf("row%0d_frames", r), 32'(fdc), 32'(tbl[r].fd));
            check($sformatf("row%0d_S", r), 32'(s4), 32'(tbl[r].s));
            for (int d = 0; d < 4; d++)
                check($sformatf("row%0d_on%0d", r, d), 32'(onc[d]), 32'(tbl[r].on[d]));
        end

        // Asynchronous clear in the middle of the digit-2 slot.
        en4 = 4'hF; bright = 3'd7; mk4 = 4'h0; bp = 1'b0; tick = 1'b0;
        do_reset();
        for (int e = 0; e < 20; e++) begin
            tick = 1'b1; cyc();
            tick = 1'b0; cyc();
        end
        check("preclr_s4", 32'(s4), 2);
        #2 clr = 1'b1;
        #1;
        check("midclr_s4", 32'(s4), 0);
        check("midclr_an4", 32'(an4), 32'hF);
        check("midclr_fd4", 32'(fd4), 0);
        mreset(0, 1'b1);
        mreset(1, 1'b0);
        @(negedge clk);
        clr = 1'b0;

        // Strobe already high at reset release counts as exactly one edge.
        bright = 3'd1; clr = 1'b1; tick = 1'b1;
        mreset(0, 1'b1);
        mreset(1, 1'b0);
        @(negedge clk);
        clr = 1'b0;
        cyc();
        check("hold_an4_first", 32'(an4), 32'hE);
        cyc();
        check("hold_an4_dark", 32'(an4), 32'hF);
        check("hold_ph", 32'(dut4.ph_q), 1);
        cyc();
        check("hold_ph_stays", 32'(dut4.ph_q), 1);
        tick = 1'b0;

        // Randomized run, both instances against the model every clock.
        en4 = 4'hF; en6 = 6'h3F; bright = 3'd5;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            tick = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 63) == 0) begin
                en4 = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
                en6 = ($urandom_range(0, 1) == 1) ? 6'h3F : 6'($urandom);
            end
            if ($urandom_range(0, 31) == 0) bright = 3'($urandom);
            if ($urandom_range(0, 47) == 0) begin
                mk4 = 4'($urandom);
                mk6 = 6'($urandom);
            end
            if ($urandom_range(0, 29) == 0) bp = ~bp;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
